uart_tx_fifo: RTL and testbench

Byte-oriented UART transmitter with a built-in transmit FIFO. It produces 8N1 serial frames, LSB first, on o_TX_serial. It sits upstream of Top_UART_Rx: on the FPGA it drives the PC's RX line, and on the bench it drives i_Rx_serial directly in loopback. The FIFO decouples bursty byte producers from the fixed serial bit rate.

---
 rtl/uart_tx_fifo.sv | 215 +++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   8N1 UART transmitter (LSB first) fed by a FIFO_DEPTH-entry byte FIFO.
//   Producers push bytes in bursts; the FSM drains them at the serial bit rate.
//   Queued bytes are sent back-to-back with no idle gap between frames.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst_n      asynchronous active-low reset; aborts any frame, empties FIFO
//   i_TX_DV      push strobe for i_TX_byte
//   i_TX_byte    byte to queue
//   o_TX_serial  serial line, idles high (registered)
//   o_TX_active  high during start/data/stop bits
//   o_TX_done    one-cycle pulse after each stop bit
//   o_full       FIFO holds FIFO_DEPTH entries
//   o_empty      FIFO holds no entries
//   o_overflow   sticky: a push was rejected (cleared only by reset)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_byte,
    output logic       o_TX_serial,
    output logic       o_TX_active,
    output logic       o_TX_done,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_overflow
);

    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;

    logic [7:0]        mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;

    logic              serial_q, serial_d;
    logic              active_q, active_d;
    logic              done_q, done_d;

    logic              baud_end;
    logic              pop;
    logic              push;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    always_comb begin
        baud_end = (baud_q == BAUD_LAST);
        // The FSM takes the head byte either from IDLE or right at the end of
        // a stop bit, which is what makes queued frames contiguous.
        pop  = !empty_q && ((state_q == IDLE) || ((state_q == STOP) && baud_end));
        // A full FIFO still accepts a byte if a slot frees up on the same edge.
        push = i_TX_DV && (!full_q || pop);

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end

        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
        ovf_d   = ovf_q | (i_TX_DV & ~push);
    end

    // Storage is not reset; only the pointers/count define what is valid.
    // When full with a simultaneous pop, wr_ptr == rd_ptr: the FSM captures the
    // old head on this edge while the new byte lands in the same slot.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr_q] <= i_TX_byte;
        end
    end

    // ------------------------------------------------------------------
    // Transmit FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (pop) begin
                    shift_d = mem[rd_ptr_q];
                    state_d = START;
                end
            end
            START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    done_d = 1'b1;
                    if (pop) begin
                        shift_d = mem[rd_ptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                baud_d  = '0;
                bit_d   = '0;
                state_d = IDLE;
            end
        endcase

        // Line level is decoded from the next state so the output comes
        // straight from a flop and changes exactly on the bit boundary.
        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[0];
            default: serial_d = 1'b1;
        endcase
        active_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign o_TX_serial = serial_q;
    assign o_TX_active = active_q;
    assign o_TX_done   = done_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_overflow  = ovf_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Directed bench for uart_tx_fifo. Accepted pushes go into a scoreboard
//   queue; a line monitor (standing in for the loopback receiver) pops the
//   expected byte at each start bit and checks every bit over its full period.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int CPB   = 87;
    localparam int FRAME = 10 * CPB;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_TX_DV = 1'b0;
    logic [7:0] i_TX_byte = 8'h00;
    logic       o_TX_serial, o_TX_active, o_TX_done, o_full, o_empty, o_overflow;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(16), .ADDR_W(4)) dut (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_TX_DV    (i_TX_DV),
        .i_TX_byte  (i_TX_byte),
        .o_TX_serial(o_TX_serial),
        .o_TX_active(o_TX_active),
        .o_TX_done  (o_TX_done),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge i_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // ------------------------------------------------------------------
    // Scoreboard + line monitor
    // ------------------------------------------------------------------
    logic [7:0] sb[$];
    int         fstart[$];
    int         mcyc     = -1;
    logic [9:0] mbits    = '1;
    logic [7:0] mexp     = 8'h00;
    logic       mbad     = 1'b0;
    logic       mdone    = 1'b0;
    int         nfdone   = 0;
    int         ndone    = 0;
    int         act_run  = 0;
    int         last_run = 0;

    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            mcyc    = -1;
            mdone   = 1'b0;
            act_run = 0;
        end else begin
            if (o_TX_done) ndone++;
            if (o_TX_active) act_run++;
            else if (act_run != 0) begin
                last_run = act_run;
                act_run  = 0;
            end
            if (mdone) begin
                chk("done_pulse", o_TX_done, 1);
                mdone = 1'b0;
            end
            if (mcyc < 0 && o_TX_serial === 1'b0) begin
                mcyc = 0;
                fstart.push_back(cyc);
                chk("frame_expected", sb.size() != 0, 1);
                if (sb.size() != 0) mexp = sb.pop_front();
                else mexp = 8'hxx;
                mbits = {1'b1, mexp, 1'b0};
                mbad  = 1'b0;
            end
            if (mcyc >= 0) begin
                if (o_TX_serial !== mbits[mcyc / CPB] || o_TX_active !== 1'b1) mbad = 1'b1;
                if (mcyc % CPB == CPB - 1) begin
                    chk($sformatf("bit%0d_of_byte_%02h_bad", mcyc / CPB, mexp), mbad, 0);
                    mbad = 1'b0;
                end
                mcyc++;
                if (mcyc == FRAME) begin
                    mcyc  = -1;
                    mdone = 1'b1;
                    nfdone++;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers (called at #1 after a rising edge)
    // ------------------------------------------------------------------
    task automatic push(input logic [7:0] b, input bit acc);
        i_TX_DV   = 1'b1;
        i_TX_byte = b;
        if (acc) sb.push_back(b);
        @(posedge i_clk); #1;
        i_TX_DV = 1'b0;
    endtask

    task automatic wait_drain(input int max, input string tag);
        int i;
        i = 0;
        while (i < max && !(sb.size() == 0 && mcyc < 0 && !o_TX_active && o_empty)) begin
            @(posedge i_clk); #1;
            i++;
        end
        chk({tag, "_drained"}, i < max, 1);
        repeat (3) @(posedge i_clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) begin
            @(posedge i_clk); #1;
        end
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        sb.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int t_load, nf0, nd0, gap;

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_serial", o_TX_serial, 1);
        chk("rst_active", o_TX_active, 0);
        chk("rst_done", o_TX_done, 0);
        chk("rst_full", o_full, 0);
        chk("rst_empty", o_empty, 1);
        chk("rst_overflow", o_overflow, 0);
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;

        // 1: single byte, latency and frame shape
        fstart.delete(); nf0 = nfdone; nd0 = ndone;
        push(8'h56, 1);
        chk("t1_line_high_after_write", o_TX_serial, 1);
        chk("t1_empty_after_write", o_empty, 0);
        @(posedge i_clk); #1;
        t_load = cyc;
        chk("t1_line_falls", o_TX_serial, 0);
        chk("t1_active", o_TX_active, 1);
        chk("t1_empty_after_load", o_empty, 1);
        wait_drain(3000, "t1");
        chk("t1_frames", nfdone - nf0, 1);
        chk("t1_done_pulses", ndone - nd0, 1);
        chk("t1_frame_start", fstart[0], t_load);

        // 2: three consecutive pushes, contiguous frames
        fstart.delete(); nf0 = nfdone; nd0 = ndone; last_run = 0;
        push(8'h41, 1);
        push(8'h42, 1);
        push(8'h43, 1);
        wait_cyc(fstart[0] + 2 * FRAME - 1);
        chk("t2_not_empty_before_3rd_load", o_empty, 0);
        @(posedge i_clk); #1;
        chk("t2_empty_after_3rd_load", o_empty, 1);
        wait_drain(4000, "t2");
        chk("t2_frames", nfdone - nf0, 3);
        chk("t2_done_pulses", ndone - nd0, 3);
        chk("t2_gap01", fstart[1] - fstart[0], FRAME);
        chk("t2_gap12", fstart[2] - fstart[1], FRAME);
        chk("t2_active_run", last_run, 3 * FRAME);

        // 3: fill during a frame, 17th push overflows
        nf0 = nfdone;
        push(8'h99, 1);
        @(posedge i_clk); #1;
        for (int i = 0; i < 17; i++) begin
            push(8'(i), i < 16);
            if (i == 14) chk("t3_not_full_at_15", o_full, 0);
            if (i == 15) begin
                chk("t3_full_at_16", o_full, 1);
                chk("t3_no_overflow_yet", o_overflow, 0);
            end
        end
        chk("t3_overflow", o_overflow, 1);
        chk("t3_still_full", o_full, 1);
        wait_drain(20000, "t3");
        chk("t3_overflow_sticky", o_overflow, 1);
        chk("t3_frames", nfdone - nf0, 17);

        // 4: push into a full FIFO on the pop edge
        do_reset();
        chk("t4_overflow_cleared", o_overflow, 0);
        nf0 = nfdone;
        push(8'h77, 1);
        @(posedge i_clk); #1;
        t_load = cyc;
        for (int i = 0; i < 16; i++) push(8'h60 + 8'(i), 1);
        chk("t4_full", o_full, 1);
        wait_cyc(t_load + FRAME - 1);
        push(8'hAA, 1);
        chk("t4_overflow_clear", o_overflow, 0);
        chk("t4_full_after_swap", o_full, 1);
        wait_drain(20000, "t4");
        chk("t4_overflow_final", o_overflow, 0);
        chk("t4_frames", nfdone - nf0, 18);

        // 5: reset in the middle of a data bit with bytes queued
        push(8'h5A, 1);
        @(posedge i_clk); #1;
        push(8'h01, 1);
        push(8'h02, 1);
        push(8'h03, 1);
        repeat (CPB + 40) @(posedge i_clk);
        #1;
        chk("t5_line_low_pre_reset", o_TX_serial, 0);
        i_rst_n = 1'b0;
        #1;
        chk("t5_line_high_in_reset", o_TX_serial, 1);
        chk("t5_empty_in_reset", o_empty, 1);
        chk("t5_inactive_in_reset", o_TX_active, 0);
        sb.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        fstart.delete(); nf0 = nfdone;
        repeat (2000) @(posedge i_clk);
        #1;
        chk("t5_no_frame_after_reset", fstart.size(), 0);
        chk("t5_line_idle", o_TX_serial, 1);
        push(8'h33, 1);
        wait_drain(3000, "t5");
        chk("t5_frames", nfdone - nf0, 1);

        // 6: push on the stop-completion edge of a lone frame
        fstart.delete(); nf0 = nfdone; nd0 = ndone;
        push(8'h11, 1);
        @(posedge i_clk); #1;
        t_load = cyc;
        wait_cyc(t_load + FRAME - 1);
        push(8'h22, 1);
        wait_drain(3000, "t6");
        chk("t6_frames", nfdone - nf0, 2);
        chk("t6_done_pulses", ndone - nd0, 2);
        gap = fstart[1] - fstart[0];
        chk("t6_gap_ok", (gap == FRAME) || (gap == FRAME + 1), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
